morse_game_ctrl_multi: RTL and testbench

//  Parametrised game-control FSM for the Morse quiz, replacing the fixed 4-bit/2-digit controller.

---
 rtl/morse_game_pkg.sv | 28 ++
 rtl/morse_game_ctrl_multi_score.sv | 56 +++++
 rtl/morse_game_ctrl_multi.sv | 217 +++++++++++++++++++++
 tb/tb_morse_game_ctrl_multi.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_game_pkg.sv
// Shared types for the Morse quiz game controller: FSM states, BCD digit type
// and score sizing helpers.
package morse_game_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      RECONFIG   = 3'd1,
      WAIT_START = 3'd2,
      ISSUE      = 3'd3,
      WAIT_ANS   = 3'd4,
      COMPARE    = 3'd5,
      GAME_OVER  = 3'd6
   } state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

   function automatic int scoreWidth(input int digits);
      return 4 * digits;
   endfunction

   // States in which a round is in progress and a symbol is on the display.
   function automatic logic isActive(input state_t s);
      return (s == ISSUE) || (s == WAIT_ANS) || (s == COMPARE);
   endfunction

endpackage

// File: rtl/morse_game_ctrl_multi_score.sv
// Multi-digit BCD score counter with synchronous clear, increment and
// saturation at all-nines.
module bcd_score_counter
   import morse_game_pkg::*;
#(
   parameter int SCORE_DIGITS = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                clr_i,
   input  logic                                inc_i,
   output logic [scoreWidth(SCORE_DIGITS)-1:0] score_o,
   output logic                                sat_o
);

   localparam int SCORE_W = scoreWidth(SCORE_DIGITS);

   logic [SCORE_W-1:0] score_q, score_d;
   logic               carry;
   bcd_digit_t         digit;

   always_comb begin
      sat_o = 1'b1;
      for (int i = 0; i < SCORE_DIGITS; i++) begin
         if (score_q[4*i +: 4] != BCD_MAX) sat_o = 1'b0;
      end
   end

   // Ripple the carry upward; once saturated the increment is dropped so the
   // score never wraps back to zero.
   always_comb begin
      score_d = score_q;
      carry   = inc_i & ~sat_o;
      digit   = '0;
      for (int i = 0; i < SCORE_DIGITS; i++) begin
         digit = score_q[4*i +: 4];
         if (carry) begin
            if (digit == BCD_MAX) begin
               score_d[4*i +: 4] = '0;
            end else begin
               score_d[4*i +: 4] = digit + 4'd1;
               carry             = 1'b0;
            end
         end
      end
      if (clr_i) score_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) score_q <= '0;
      else      score_q <= score_d;
   end

   assign score_o = score_q;

endmodule

// File: rtl/morse_game_ctrl_multi.sv
// Game-control FSM for the Morse quiz: ROM reconfig, symbol issue, answer
// timing, scoring, lives and session logout.
module morse_game_ctrl_multi
   import morse_game_pkg::*;
#(
   parameter int SYM_W        = 4,
   parameter int SCORE_DIGITS = 2,
   parameter int MAX_LIVES    = 3,
   parameter int ROUND_CYCLES = 1000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      logged_in_i,
   input  logic                      game_start_i,
   input  logic                      logout_i,
   input  logic                      timeout_i,
   input  logic [SYM_W-1:0]          morse_number_i,
   input  logic                      load_i,
   input  logic [SYM_W-1:0]          user_input_i,
   output logic                      reconfig_o,
   output logic                      enable_o,
   output logic [SYM_W-1:0]          number_o,
   output logic [4*SCORE_DIGITS-1:0] score_bcd_o,
   output logic                      correct_o,
   output logic [3:0]                lives_left_o,
   output logic                      game_over_o,
   output logic                      logout_ack_o
);

   localparam int               TMR_W      = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(ROUND_CYCLES - 1);
   localparam logic [3:0]       LIVES_INIT = 4'(MAX_LIVES);

   state_t                    state_q, state_d;
   logic [SYM_W-1:0]          number_q, number_d;
   logic [SYM_W-1:0]          entry_q, entry_d;
   logic [TMR_W-1:0]          timer_q, timer_d;
   logic [3:0]                lives_q, lives_d;
   logic                      correct_q, correct_d;
   logic                      expired_q, expired_d;
   logic                      logout_ack_q, logout_ack_d;
   logic                      roundEnd, isMatch, compareEn;
   logic                      scoreInc, scoreClr, scoreSat;
   logic [4*SCORE_DIGITS-1:0] scoreVal;

   // A round ends on an answer or on the last permitted cycle; an expired
   // round can never match, so it counts as a wrong answer.
   assign roundEnd = load_i | (timer_q == TMR_LAST);
   assign isMatch  = ~expired_q & (entry_q == number_q);

   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      logout_ack_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (logged_in_i) state_d = RECONFIG;
         end
         RECONFIG: begin
            state_d = WAIT_START;
         end
         WAIT_START: begin
            if (logout_i) begin
               state_d      = IDLE;
               logout_ack_d = 1'b1;
            end else if (game_start_i) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (logout_i) begin
               state_d      = IDLE;
               logout_ack_d = 1'b1;
            end else if (timeout_i) begin
               state_d = GAME_OVER;
            end else begin
               state_d = WAIT_ANS;
            end
         end
         WAIT_ANS: begin
            if (logout_i) begin
               state_d      = IDLE;
               logout_ack_d = 1'b1;
            end else if (timeout_i) begin
               state_d = GAME_OVER;
            end else if (roundEnd) begin
               state_d = COMPARE;
            end
         end
         COMPARE: begin
            if (logout_i) begin
               state_d      = IDLE;
               logout_ack_d = 1'b1;
            end else if (timeout_i) begin
               state_d = GAME_OVER;
            end else if (!isMatch && (lives_q <= 4'd1)) begin
               state_d = GAME_OVER;
            end else begin
               state_d = ISSUE;
            end
         end
         GAME_OVER: begin
            if (logout_i) begin
               state_d      = IDLE;
               logout_ack_d = 1'b1;
            end else if (game_start_i) begin
               state_d = RECONFIG;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Score, lives and result are reinitialised on the way into IDLE or
   // RECONFIG so they already read as fresh values in those states.
   always_comb begin
      compareEn = (state_q == COMPARE) & ~logout_i & ~timeout_i;
      scoreClr  = (state_d == IDLE) | (state_d == RECONFIG);
      scoreInc  = compareEn & isMatch & ~scoreSat;

      number_d = number_q;
      if (state_q == ISSUE) number_d = morse_number_i;
      if (!isActive(state_d)) number_d = '0;

      timer_d = timer_q;
      if (state_q == ISSUE)         timer_d = '0;
      else if (state_q == WAIT_ANS) timer_d = timer_q + 1'b1;

      entry_d   = entry_q;
      expired_d = expired_q;
      if (state_q == WAIT_ANS) begin
         if (load_i) begin
            entry_d   = user_input_i;
            expired_d = 1'b0;
         end else if (timer_q == TMR_LAST) begin
            expired_d = 1'b1;
         end
      end
      if (scoreClr) begin
         entry_d   = '0;
         expired_d = 1'b0;
      end

      lives_d   = lives_q;
      correct_d = correct_q;
      if (scoreClr) begin
         lives_d   = LIVES_INIT;
         correct_d = 1'b0;
      end else if (compareEn) begin
         correct_d = isMatch;
         if (!isMatch) lives_d = lives_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         number_q     <= '0;
         entry_q      <= '0;
         timer_q      <= '0;
         lives_q      <= LIVES_INIT;
         correct_q    <= 1'b0;
         expired_q    <= 1'b0;
         logout_ack_q <= 1'b0;
      end else begin
         number_q     <= number_d;
         entry_q      <= entry_d;
         timer_q      <= timer_d;
         lives_q      <= lives_d;
         correct_q    <= correct_d;
         expired_q    <= expired_d;
         logout_ack_q <= logout_ack_d;
      end
   end

   bcd_score_counter #(
      .SCORE_DIGITS(SCORE_DIGITS)
   ) u_score (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (scoreClr),
      .inc_i  (scoreInc),
      .score_o(scoreVal),
      .sat_o  (scoreSat)
   );

   always_comb begin
      reconfig_o   = 1'b0;
      enable_o     = 1'b0;
      number_o     = '0;
      score_bcd_o  = '0;
      correct_o    = 1'b0;
      lives_left_o = LIVES_INIT;
      game_over_o  = 1'b0;
      logout_ack_o = 1'b0;
      case (state_q)
         IDLE, RECONFIG, WAIT_START, ISSUE, WAIT_ANS, COMPARE, GAME_OVER: begin
            reconfig_o   = (state_q == RECONFIG);
            enable_o     = isActive(state_q);
            number_o     = number_q;
            score_bcd_o  = scoreVal;
            correct_o    = correct_q;
            lives_left_o = lives_q;
            game_over_o  = (state_q == GAME_OVER);
            logout_ack_o = logout_ack_q;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_morse_game_ctrl_multi.sv
// Self-checking bench for morse_game_ctrl_multi: table of answer vectors,
// saturation run, round expiry, timeout, logout and mid-game reset.
module tb_morse_game_ctrl_multi;

   localparam int SYM_W        = 4;
   localparam int SCORE_DIGITS = 2;
   localparam int MAX_LIVES    = 3;
   localparam int ROUND_CYCLES = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       logged_in = 1'b0;
   logic       game_start = 1'b0;
   logic       logout = 1'b0;
   logic       timeout = 1'b0;
   logic [3:0] morse_number = '0;
   logic       load = 1'b0;
   logic [3:0] user_input = '0;
   logic       reconfig, enable, correct, game_over, logout_ack;
   logic [3:0] number, lives_left;
   logic [7:0] score_bcd;

   typedef struct {
      logic       expCorrect;
      logic [7:0] expScore;
      logic [3:0] expLives;
      logic       expGameOver;
   } result_t;

   typedef struct {
      logic [3:0] sym;
      logic [3:0] ans;
      result_t    res;
   } vector_t;

   result_t expQ[$];
   vector_t vecs[14];
   int      nVectors = 0;
   int      nMiscompares = 0;

   always #5 clk = ~clk;

   morse_game_ctrl_multi #(
      .SYM_W       (SYM_W),
      .SCORE_DIGITS(SCORE_DIGITS),
      .MAX_LIVES   (MAX_LIVES),
      .ROUND_CYCLES(ROUND_CYCLES)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .logged_in_i   (logged_in),
      .game_start_i  (game_start),
      .logout_i      (logout),
      .timeout_i     (timeout),
      .morse_number_i(morse_number),
      .load_i        (load),
      .user_input_i  (user_input),
      .reconfig_o    (reconfig),
      .enable_o      (enable),
      .number_o      (number),
      .score_bcd_o   (score_bcd),
      .correct_o     (correct),
      .lives_left_o  (lives_left),
      .game_over_o   (game_over),
      .logout_ack_o  (logout_ack)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkResult(input string tag);
      result_t r;
      if (expQ.size() == 0) begin
         checkOutput({tag, " scoreboard underflow"}, 32'd0, 32'd1);
      end else begin
         r = expQ.pop_front();
         checkOutput({tag, " correct"}, correct, r.expCorrect);
         checkOutput({tag, " score"}, score_bcd, r.expScore);
         checkOutput({tag, " lives"}, lives_left, r.expLives);
         checkOutput({tag, " game_over"}, game_over, r.expGameOver);
         checkOutput({tag, " enable"}, enable, !r.expGameOver);
         if (r.expGameOver) checkOutput({tag, " number"}, number, 0);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, " reconfig"}, reconfig, 0);
      checkOutput({tag, " enable"}, enable, 0);
      checkOutput({tag, " number"}, number, 0);
      checkOutput({tag, " score"}, score_bcd, 0);
      checkOutput({tag, " correct"}, correct, 0);
      checkOutput({tag, " lives"}, lives_left, MAX_LIVES);
      checkOutput({tag, " game_over"}, game_over, 0);
      checkOutput({tag, " logout_ack"}, logout_ack, 0);
   endtask

   // Starts in IDLE (logged in) or GAME_OVER and ends in the first ISSUE cycle.
   task automatic startGame(input string tag);
      logged_in  = 1'b1;
      game_start = 1'b1;
      tick();
      checkOutput({tag, " reconfig pulse"}, reconfig, 1);
      checkOutput({tag, " score reinit"}, score_bcd, 0);
      checkOutput({tag, " lives reinit"}, lives_left, MAX_LIVES);
      tick();
      checkOutput({tag, " reconfig single"}, reconfig, 0);
      tick();
      game_start = 1'b0;
      checkOutput({tag, " enable in issue"}, enable, 1);
   endtask

   // One answer round, entered and left in ISSUE (or GAME_OVER).
   task automatic applyStimulus(input string tag, input logic [3:0] sym, input logic [3:0] ans,
                                input result_t exp);
      morse_number = sym;
      tick();
      checkOutput({tag, " number"}, number, sym);
      load       = 1'b1;
      user_input = ans;
      expQ.push_back(exp);
      tick();
      load = 1'b0;
      tick();
      checkResult(tag);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int      modelScore;
      result_t r;

      vecs[0]  = '{4'd5,  4'd5, '{1'b1, 8'h01, 4'd3, 1'b0}};
      vecs[1]  = '{4'd5,  4'd5, '{1'b1, 8'h02, 4'd3, 1'b0}};
      vecs[2]  = '{4'd5,  4'd5, '{1'b1, 8'h03, 4'd3, 1'b0}};
      vecs[3]  = '{4'd7,  4'd3, '{1'b0, 8'h03, 4'd2, 1'b0}};
      vecs[4]  = '{4'd9,  4'd9, '{1'b1, 8'h04, 4'd2, 1'b0}};
      vecs[5]  = '{4'd2,  4'd2, '{1'b1, 8'h05, 4'd2, 1'b0}};
      vecs[6]  = '{4'd3,  4'd3, '{1'b1, 8'h06, 4'd2, 1'b0}};
      vecs[7]  = '{4'd4,  4'd4, '{1'b1, 8'h07, 4'd2, 1'b0}};
      vecs[8]  = '{4'd6,  4'd6, '{1'b1, 8'h08, 4'd2, 1'b0}};
      vecs[9]  = '{4'd1,  4'd1, '{1'b1, 8'h09, 4'd2, 1'b0}};
      vecs[10] = '{4'd8,  4'd8, '{1'b1, 8'h10, 4'd2, 1'b0}};
      vecs[11] = '{4'd0,  4'd1, '{1'b0, 8'h10, 4'd1, 1'b0}};
      vecs[12] = '{4'd15, 4'd15, '{1'b1, 8'h11, 4'd1, 1'b0}};
      vecs[13] = '{4'd3,  4'd4, '{1'b0, 8'h11, 4'd0, 1'b1}};

      tick();
      tick();
      checkReset("reset");
      rst = 1'b1;

      // Game 1: table of answers ending in game over on the last life.
      startGame("game1");
      for (int i = 0; i < 14; i++) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i].sym, vecs[i].ans, vecs[i].res);
      end

      // Game 2: round expiry, answer on the expiry cycle, then timeout with load.
      startGame("game2");
      morse_number = 4'd6;
      tick();
      expQ.push_back('{1'b0, 8'h00, 4'd2, 1'b0});
      for (int i = 0; i < ROUND_CYCLES - 1; i++) tick();
      tick();
      checkOutput("expiry not early lives", lives_left, 3);
      tick();
      checkResult("expiry");

      morse_number = 4'd6;
      tick();
      for (int i = 0; i < ROUND_CYCLES - 1; i++) tick();
      load       = 1'b1;
      user_input = 4'd6;
      expQ.push_back('{1'b1, 8'h01, 4'd2, 1'b0});
      tick();
      load = 1'b0;
      tick();
      checkResult("load on expiry");

      logged_in    = 1'b0;
      morse_number = 4'd2;
      tick();
      checkOutput("logged_in drop no effect", enable, 1);
      timeout    = 1'b1;
      load       = 1'b1;
      user_input = 4'd2;
      expQ.push_back('{1'b1, 8'h01, 4'd2, 1'b1});
      tick();
      timeout = 1'b0;
      load    = 1'b0;
      checkResult("timeout with load");
      tick();
      checkOutput("score frozen in game over", score_bcd, 8'h01);

      logout     = 1'b1;
      game_start = 1'b1;
      tick();
      logout     = 1'b0;
      game_start = 1'b0;
      checkOutput("logout ack", logout_ack, 1);
      checkOutput("logout game_over", game_over, 0);
      checkOutput("logout reconfig", reconfig, 0);
      checkOutput("logout score", score_bcd, 0);
      checkOutput("logout lives", lives_left, MAX_LIVES);
      tick();
      checkOutput("logout ack single", logout_ack, 0);
      checkOutput("idle without login", reconfig, 0);

      // Game 3: 100 correct answers through carry and saturation.
      startGame("game3");
      modelScore = 0;
      for (int i = 0; i < 100; i++) begin
         modelScore = (modelScore < 99) ? modelScore + 1 : 99;
         r = '{1'b1, 8'((modelScore / 10) * 16 + (modelScore % 10)), 4'd3, 1'b0};
         applyStimulus($sformatf("sat%0d", i), 4'(i % 16), 4'(i % 16), r);
      end

      // Synchronous reset in the middle of WAIT_ANS.
      morse_number = 4'd4;
      tick();
      rst = 1'b0;
      tick();
      checkReset("mid-game reset");
      rst       = 1'b1;
      logged_in = 1'b0;
      tick();
      checkOutput("no reconfig before login", reconfig, 0);
      logged_in = 1'b1;
      tick();
      checkOutput("reconfig after login", reconfig, 1);
      tick();
      checkOutput("reconfig one cycle", reconfig, 0);

      checkOutput("scoreboard drained", expQ.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
